muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/div_restoring_step.sv | 23 ++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and the iteration count.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;
    localparam int CNT_W       = $clog2(MULDIV_ITER);

    // Codes 6 and 7 are reserved and ignored by the unit.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    // Signed operations take absolute values and fix the sign at the end.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: try to subtract the divisor from the
// shifted partial remainder and keep the difference only if it did not go
// negative. Purely combinational.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // The incoming remainder is always below twice the divisor, so the top
    // bit of the difference is set exactly when the subtraction underflows.
    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies run as 32 radix-2 shift-add steps, divides as 32 restoring
// steps, followed by a single sign-fix cycle that commits HI/LO.
// Build option: define MULDIV_DIV_EN to include the divider datapath;
// without it DIV/DIVU are accepted as single-cycle no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULDIV_ITER - 1);

    muldiv_state_e      state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               neg_result;

    logic               signed_op;
    logic               sign_diff;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] product;

    // Convert request operands to magnitudes and work out the result sign.
    always_comb begin
        signed_op = op_is_signed(op);
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
        sign_diff = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Shift-add multiply step: upper half accumulates, lower half holds the
    // not-yet-consumed multiplier bits; the whole register shifts right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        product  = neg_result ? -acc : acc;
    end

`ifdef MULDIV_DIV_EN
    logic             calc_div;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_saved;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // For divides acc holds {remainder, dividend}; dividend bits shift out
    // of the top of the lower half while quotient bits shift in at the bottom.
    div_restoring_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in  ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor (operand),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

    // Select the active datapath step and sign-fix the divide results.
    always_comb begin
        step_next = calc_div ? {div_rem, acc[WIDTH-2:0], div_q} : mul_next;
        quotient  = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`else
    // Only the multiplier exists in this build.
    always_comb begin
        step_next = mul_next;
    end
`endif

    // Control FSM plus HI/LO and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            acc        <= '0;
            operand    <= '0;
            neg_result <= 1'b0;
`ifdef MULDIV_DIV_EN
            calc_div   <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            a_saved    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU: begin
                                acc        <= {{WIDTH{1'b0}}, b_mag};
                                operand    <= a_mag;
                                neg_result <= sign_diff;
                                count      <= '0;
                                busy       <= 1'b1;
                                state      <= ST_CALC;
`ifdef MULDIV_DIV_EN
                                calc_div   <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                                acc        <= {{WIDTH{1'b0}}, a_mag};
                                operand    <= b_mag;
                                neg_result <= sign_diff;
                                neg_rem    <= signed_op && a[WIDTH-1];
                                div_zero   <= (b == '0);
                                a_saved    <= a;
                                calc_div   <= 1'b1;
                                count      <= '0;
                                busy       <= 1'b1;
                                state      <= ST_CALC;
`else
                                done       <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc   <= step_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (calc_div) begin
                        if (div_zero) begin
                            lo <= {WIDTH{1'b1}};
                            hi <= a_saved;
                        end else begin
                            lo <= quotient;
                            hi <= remainder;
                        end
                    end else begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end
`else
                    hi <= product[2*WIDTH-1:WIDTH];
                    lo <= product[WIDTH-1:0];
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected HI/LO values come from a
// native-arithmetic model and are queued when a request is driven, then
// popped when the unit signals done. Follows MULDIV_DIV_EN like the RTL.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam int DIV_WAIT = 33;
`else
    localparam int DIV_WAIT = 0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          check_count;
    int          pass_count;

    muldiv_unit #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: update architectural HI/LO and queue completions.
    task automatic predict(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            OP_MTHI: model_hi = av;
            OP_MTLO: model_lo = av;
            OP_MULT, OP_MULTU: begin
                if (o == OP_MULT) p = 64'(sa * sb);
                else              p = {32'd0, av} * {32'd0, bv};
                model_hi = p[63:32];
                model_lo = p[31:0];
                exp_q.push_back('{hi: model_hi, lo: model_lo});
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (bv == 32'd0) begin
                    model_lo = 32'hFFFF_FFFF;
                    model_hi = av;
                end else if (o == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end else begin
                    model_lo = av / bv;
                    model_hi = av % bv;
                end
`endif
                exp_q.push_back('{hi: model_hi, lo: model_lo});
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge: drive one request for exactly one cycle.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        predict(o, av, bv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then compare timing and the queued result.
    task automatic collectResult(input string tag, input int exp_wait, input int exp_busy,
                                 input bit check_pulse);
        int   waited;
        int   busy_cycles;
        exp_t e;
        waited      = 0;
        busy_cycles = 0;
        while (!done && waited < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_wait"}, 64'(waited), 64'(exp_wait));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
        checkOutput({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
            checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        end
        if (check_pulse) begin
            @(negedge clk);
            checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        logic [2:0]  d_op [6];
        logic [31:0] d_a  [6];
        logic [31:0] d_b  [6];
        logic [31:0] ra;
        logic [31:0] rb;
        int          done_seen;

        check_count = 0;
        pass_count  = 0;
        model_hi    = '0;
        model_lo    = '0;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_hi", {32'd0, hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] MTHI/MTLO on consecutive cycles");
        applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
        checkOutput("mthi_hi", {32'd0, hi}, {32'd0, model_hi});
        checkOutput("mthi_busy", {63'd0, busy}, 64'd0);
        applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        checkOutput("mtlo_lo", {32'd0, lo}, {32'd0, model_lo});
        checkOutput("mtlo_hi", {32'd0, hi}, {32'd0, model_hi});
        checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);
        checkOutput("mtlo_done", {63'd0, done}, 64'd0);

        $display("[TB] multiply directed cases");
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        collectResult("multu_max", 33, 33, 1'b1);
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        collectResult("mult_neg", 33, 33, 1'b0);
        applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        collectResult("mult_b2b", 33, 33, 1'b1);
        applyStimulus(OP_MULT, 32'h8000_0000, 32'd3);
        collectResult("mult_minneg", 33, 33, 1'b1);

        $display("[TB] multiply random cases");
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus((i % 2 == 0) ? OP_MULT : OP_MULTU, ra, rb);
            collectResult("mult_rand", 33, 33, 1'b1);
        end

        $display("[TB] MTLO while busy is ignored");
        applyStimulus(OP_MULT, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        collectResult("mtlo_busy", 27, 27, 1'b1);
        checkOutput("mtlo_busy_lo_after", {32'd0, lo}, {32'd0, model_lo});

        $display("[TB] divide cases with HI/LO preloaded");
        applyStimulus(OP_MTHI, 32'h55, 32'd0);
        applyStimulus(OP_MTLO, 32'h55, 32'd0);
        d_op[0] = OP_DIV;  d_a[0] = 32'd7;          d_b[0] = 32'd2;
        d_op[1] = OP_DIV;  d_a[1] = 32'hFFFF_FFF9;  d_b[1] = 32'd2;
        d_op[2] = OP_DIVU; d_a[2] = 32'd100;        d_b[2] = 32'd0;
        d_op[3] = OP_DIV;  d_a[3] = 32'h8000_0000;  d_b[3] = 32'hFFFF_FFFF;
        d_op[4] = OP_DIV;  d_a[4] = 32'hFFFF_FFF9;  d_b[4] = 32'd0;
        d_op[5] = OP_DIV;  d_a[5] = 32'd7;          d_b[5] = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(d_op[i], d_a[i], d_b[i]);
            collectResult($sformatf("div%0d", i), DIV_WAIT, DIV_WAIT, 1'b1);
        end
        ra = $urandom;
        rb = $urandom_range(32'hFFFF, 1);
        applyStimulus(OP_DIVU, ra, rb);
        collectResult("divu_rand", DIV_WAIT, DIV_WAIT, 1'b1);

        $display("[TB] reserved opcode does nothing");
        applyStimulus(3'd6, 32'h1111_1111, 32'h2222_2222);
        checkOutput("rsvd_busy", {63'd0, busy}, 64'd0);
        checkOutput("rsvd_done", {63'd0, done}, 64'd0);
        checkOutput("rsvd_hi", {32'd0, hi}, {32'd0, model_hi});
        checkOutput("rsvd_lo", {32'd0, lo}, {32'd0, model_lo});

        $display("[TB] reset during CALC");
        applyStimulus(OP_MTHI, 32'hCAFE_0001, 32'd0);
        applyStimulus(OP_MULT, 32'h0001_2345, 32'h0000_6789);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_done", {63'd0, done}, 64'd0);
        checkOutput("midrst_hi", {32'd0, hi}, 64'd0);
        checkOutput("midrst_lo", {32'd0, lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("midrst_no_done", 64'(done_seen), 64'd0);
        checkOutput("midrst_lo_final", {32'd0, lo}, {32'd0, model_lo});

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
